kernel_ctrl_s_axi_n: RTL and testbench



---
 rtl/kernel_ctrl_s_axi_n.sv | 226 ++++++++++++++++++++++
 tb/tb_kernel_ctrl_s_axi_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_ctrl_s_axi_n.sv
// kernel_ctrl_s_axi_n
// AXI4-Lite control slave for an RTL kernel. It exposes the kernel control
// word (ap_start / ap_done / ap_idle / ap_ready / auto_restart), an interrupt
// controller (GIE / IER / ISR) and C_NUM_ARGS 64-bit argument registers.
//
// Ports:
//   aclk, aresetn, aclk_en         clock, sync active-low reset, clock enable
//   aw*/w*/b*                      AXI-Lite write address / data / response
//   ar*/r*                         AXI-Lite read address / data
//   ap_start                       start request to the kernel
//   ap_ready, ap_done, ap_idle     kernel handshake inputs (pulse, pulse, level)
//   args                           argument i = args[64*i +: 64]
//   interrupt                      level interrupt = GIE & |ISR
module kernel_ctrl_s_axi_n #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_ARGS   = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      aclk_en,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [C_ADDR_WIDTH-1:0]   awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [C_DATA_WIDTH-1:0]   wdata,
  input  logic [C_DATA_WIDTH/8-1:0] wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [C_ADDR_WIDTH-1:0]   araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      ap_start,
  input  logic                      ap_ready,
  input  logic                      ap_done,
  input  logic                      ap_idle,
  output logic [64*C_NUM_ARGS-1:0]  args,
  output logic                      interrupt
);

  // Registers are decoded on 32-bit word addresses.
  localparam int WORD_W = C_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;

  logic [WORD_W-1:0]       waddr_reg;
  logic [WORD_W-1:0]       rd_word;
  logic [C_DATA_WIDTH-1:0] rdata_reg, rd_mux;
  logic                    ap_start_reg, auto_restart_reg, done_reg, ready_reg;
  logic                    gie_reg;
  logic [1:0]              ier_reg, isr_reg;
  logic                    aw_hs, w_hs, ar_hs, wr_en, rd_en;
  logic                    wr_ctrl, wr_isr, rd_ctrl;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // ---------------- write channel FSM ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn)
      wr_state_reg <= WRIDLE;
    else if (aclk_en)
      wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    awready       = 1'b0;
    wready        = 1'b0;
    bvalid        = 1'b0;
    case (wr_state_reg)
      WRIDLE: begin
        awready = aresetn;
        if (awvalid) wr_state_next = WRDATA;
      end
      WRDATA: begin
        wready = 1'b1;
        if (wvalid) wr_state_next = WRRESP;
      end
      WRRESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_next = WRIDLE;
      end
      default: wr_state_next = WRIDLE;
    endcase
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn)
      rd_state_reg <= RDIDLE;
    else if (aclk_en)
      rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    arready       = 1'b0;
    rvalid        = 1'b0;
    case (rd_state_reg)
      RDIDLE: begin
        arready = aresetn;
        if (arvalid) rd_state_next = RDDATA;
      end
      RDDATA: begin
        rvalid = 1'b1;
        if (rready) rd_state_next = RDIDLE;
      end
      default: rd_state_next = RDIDLE;
    endcase
  end

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign wr_en   = w_hs & aclk_en;
  assign rd_en   = ar_hs & aclk_en;
  assign rd_word = araddr[C_ADDR_WIDTH-1:2];
  assign wr_ctrl = wr_en && (waddr_reg == WORD_W'(0)) && wstrb[0];
  assign wr_isr  = wr_en && (waddr_reg == WORD_W'(3)) && wstrb[0];
  assign rd_ctrl = rd_en && (rd_word == WORD_W'(0));

  always_ff @(posedge aclk) begin
    if (!aresetn)
      waddr_reg <= '0;
    else if (aclk_en && aw_hs)
      waddr_reg <= awaddr[C_ADDR_WIDTH-1:2];
  end

  // ---------------- control / interrupt registers ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ap_start_reg     <= 1'b0;
      auto_restart_reg <= 1'b0;
      done_reg         <= 1'b0;
      ready_reg        <= 1'b0;
      gie_reg          <= 1'b0;
      ier_reg          <= 2'b00;
      isr_reg          <= 2'b00;
      rdata_reg        <= '0;
    end else if (aclk_en) begin
      // A host set beats a same-cycle ap_ready; auto_restart keeps start high.
      if (wr_ctrl && wdata[0])
        ap_start_reg <= 1'b1;
      else if (ap_ready && !auto_restart_reg)
        ap_start_reg <= 1'b0;
      if (wr_ctrl)
        auto_restart_reg <= wdata[7];
      // Sticky status: a new event wins over the read-clear.
      if (ap_done)
        done_reg <= 1'b1;
      else if (rd_ctrl)
        done_reg <= 1'b0;
      if (ap_ready)
        ready_reg <= 1'b1;
      else if (rd_ctrl)
        ready_reg <= 1'b0;
      if (wr_en && (waddr_reg == WORD_W'(1)) && wstrb[0])
        gie_reg <= wdata[0];
      if (wr_en && (waddr_reg == WORD_W'(2)) && wstrb[0])
        ier_reg <= wdata[1:0];
      // Toggle-on-write, with enabled events forcing bits set.
      isr_reg <= {ap_ready & ier_reg[1], ap_done & ier_reg[0]}
               | (isr_reg ^ (wr_isr ? wdata[1:0] : 2'b00));
      // rdata captures pre-update values, so same-edge writes/clears are not seen.
      if (rd_en)
        rdata_reg <= rd_mux;
    end
  end

  // ---------------- argument registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_ARGS; gi++) begin : g_arg
      logic [63:0] arg_reg;
      logic        wr_lo, wr_hi;
      assign wr_lo = wr_en && (waddr_reg == WORD_W'(4 + 2*gi));
      assign wr_hi = wr_en && (waddr_reg == WORD_W'(5 + 2*gi));
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          arg_reg <= '0;
        end else if (aclk_en) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_lo && wstrb[b]) arg_reg[8*b +: 8]      <= wdata[8*b +: 8];
            if (wr_hi && wstrb[b]) arg_reg[32 + 8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
      assign args[64*gi +: 64] = arg_reg;
    end
  endgenerate

  // ---------------- read decode ----------------
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      WORD_W'(0): rd_mux = {24'b0, auto_restart_reg, 3'b0, ready_reg, ap_idle, done_reg, ap_start_reg};
      WORD_W'(1): rd_mux = {31'b0, gie_reg};
      WORD_W'(2): rd_mux = {30'b0, ier_reg};
      WORD_W'(3): rd_mux = {30'b0, isr_reg};
      default: begin
        for (int i = 0; i < C_NUM_ARGS; i++) begin
          if (rd_word == WORD_W'(4 + 2*i)) rd_mux = args[64*i +: 32];
          if (rd_word == WORD_W'(5 + 2*i)) rd_mux = args[64*i + 32 +: 32];
        end
      end
    endcase
  end

  assign rdata     = rdata_reg;
  assign bresp     = 2'b00;
  assign rresp     = 2'b00;
  assign ap_start  = ap_start_reg;
  assign interrupt = gie_reg & (isr_reg[0] | isr_reg[1]);

endmodule

// File: tb/tb_kernel_ctrl_s_axi_n.sv
// Directed testbench for kernel_ctrl_s_axi_n (default parameters: 12-bit
// address, 4 arguments). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_kernel_ctrl_s_axi_n;

  logic         aclk = 1'b0;
  logic         aresetn, aclk_en;
  logic         awvalid, awready;
  logic [11:0]  awaddr;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         arvalid, arready;
  logic [11:0]  araddr;
  logic         rvalid, rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         ap_start, ap_ready, ap_done, ap_idle;
  logic [255:0] args;
  logic         interrupt;

  int assert_count = 0;
  int fail_count   = 0;
  logic [31:0]  rd;
  logic [255:0] exp_args;

  kernel_ctrl_s_axi_n dut (
    .aclk(aclk), .aresetn(aresetn), .aclk_en(aclk_en),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .args(args), .interrupt(interrupt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ev: 0 none, 1 ap_done, 2 ap_ready asserted on the W handshake edge
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int ev);
    int n;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin tick; n++; end
    chk("awready_wait", n < 20, 1);
    tick;
    awvalid = 1'b0;
    chk("wready_lat", wready, 1);
    chk("bvalid_early", bvalid, 0);
    if (ev == 1) ap_done = 1'b1;
    if (ev == 2) ap_ready = 1'b1;
    tick;
    wvalid = 1'b0; ap_done = 1'b0; ap_ready = 1'b0;
    chk("bvalid_lat", bvalid, 1);
    chk("bresp", bresp, 0);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    $display("write addr=%03h data=%08h strb=%b", a, d, s);
  endtask

  // ev: 1 pulses ap_done on the AR handshake edge
  task automatic axi_read(input logic [11:0] a, input int ev, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin tick; n++; end
    chk("arready_wait", n < 20, 1);
    if (ev == 1) ap_done = 1'b1;
    tick;
    arvalid = 1'b0; ap_done = 1'b0;
    chk("rvalid_lat", rvalid, 1);
    chk("rresp", rresp, 0);
    d = rdata;
    rready = 1'b1;
    tick;
    rready = 1'b0;
    $display("read  addr=%03h data=%08h", a, d);
  endtask

  task automatic pulse_ready;
    ap_ready = 1'b1; tick; ap_ready = 1'b0;
  endtask

  task automatic pulse_done;
    ap_done = 1'b1; tick; ap_done = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; aclk_en = 1'b1;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; rready = 0;
    ap_ready = 0; ap_done = 0; ap_idle = 1'b1;
    tick; tick; tick;

    // reset state
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_interrupt", interrupt, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_args", args, 0);
    aresetn = 1'b1;
    #1;
    chk("awready_after_rst", awready, 1);
    tick;

    // argument registers
    axi_write(12'h010, 32'hCAFEF00D, 4'hF, 0);
    chk("arg0_lo", args[63:0], 64'h00000000_CAFEF00D);
    axi_write(12'h018, 32'h12345678, 4'hF, 0);
    axi_write(12'h01C, 32'h9ABCDEF0, 4'hF, 0);
    chk("arg1", args[127:64], 64'h9ABCDEF0_12345678);
    axi_read(12'h018, 0, rd); chk("rd_arg1_lo", rd, 32'h12345678);
    axi_read(12'h01C, 0, rd); chk("rd_arg1_hi", rd, 32'h9ABCDEF0);
    axi_write(12'h018, 32'hFFFFFFFF, 4'b0001, 0);
    axi_read(12'h018, 0, rd); chk("rd_arg1_strb", rd, 32'h123456FF);

    // ap_start / ap_ready without auto_restart
    axi_write(12'h000, 32'h1, 4'hF, 0);
    chk("start_set", ap_start, 1);
    pulse_ready;
    chk("start_clr_ready", ap_start, 0);
    pulse_done;
    axi_read(12'h000, 0, rd); chk("ctrl_done_ready", rd, 32'h0E);
    axi_read(12'h000, 0, rd); chk("ctrl_cor", rd, 32'h04);

    // auto_restart
    axi_write(12'h000, 32'h81, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_ready;
      chk("start_auto", ap_start, 1);
    end
    axi_read(12'h000, 0, rd); chk("ctrl_auto", rd, 32'h8D);
    axi_write(12'h000, 32'h00, 4'hF, 0);
    chk("start_write0", ap_start, 1);
    pulse_ready;
    chk("start_clr_noauto", ap_start, 0);
    axi_read(12'h000, 0, rd); chk("ctrl_after_auto", rd, 32'h0C);

    // interrupt controller
    axi_write(12'h004, 32'h1, 4'hF, 0);
    axi_write(12'h008, 32'h1, 4'hF, 0);
    chk("irq_idle", interrupt, 0);
    pulse_done;
    chk("irq_done", interrupt, 1);
    axi_read(12'h00C, 0, rd); chk("isr_done", rd, 32'h1);
    axi_read(12'h004, 0, rd); chk("rd_gie", rd, 32'h1);
    axi_read(12'h008, 0, rd); chk("rd_ier", rd, 32'h1);
    axi_write(12'h00C, 32'h1, 4'hF, 0);
    chk("irq_cleared", interrupt, 0);
    axi_read(12'h00C, 0, rd); chk("isr_cleared", rd, 32'h0);
    axi_write(12'h008, 32'h0, 4'hF, 0);
    pulse_done;
    chk("irq_masked", interrupt, 0);
    axi_read(12'h00C, 0, rd); chk("isr_masked", rd, 32'h0);
    axi_write(12'h008, 32'h2, 4'hF, 0);
    pulse_ready;
    chk("irq_ready", interrupt, 1);
    axi_read(12'h00C, 0, rd); chk("isr_ready", rd, 32'h2);
    axi_write(12'h00C, 32'h2, 4'hF, 0);
    chk("irq_ready_clr", interrupt, 0);

    // ISR set wins over a same-cycle toggle
    axi_write(12'h008, 32'h1, 4'hF, 0);
    pulse_done;
    axi_write(12'h00C, 32'h1, 4'hF, 1);
    axi_read(12'h00C, 0, rd); chk("isr_set_wins", rd, 32'h1);
    chk("irq_set_wins", interrupt, 1);
    axi_write(12'h00C, 32'h1, 4'hF, 0);
    chk("irq_off", interrupt, 0);

    // ap_done on the same edge as a CTRL read handshake
    axi_read(12'h000, 0, rd); chk("ctrl_pre", rd, 32'h0E);
    axi_read(12'h000, 1, rd); chk("ctrl_same_cycle", rd, 32'h04);
    axi_read(12'h000, 0, rd); chk("ctrl_later", rd, 32'h06);

    // write-set of ap_start beats a same-cycle ap_ready
    axi_write(12'h000, 32'h1, 4'hF, 2);
    chk("start_set_wins", ap_start, 1);
    pulse_ready;
    chk("start_clr2", ap_start, 0);

    // unmapped accesses
    axi_read(12'h3F0, 0, rd); chk("rd_unmapped", rd, 32'h0);
    axi_write(12'h3F0, 32'hFFFFFFFF, 4'hF, 0);
    exp_args = {64'h0, 64'h0, 64'h9ABCDEF0_123456FF, 64'h00000000_CAFEF00D};
    chk("args_unmapped", args, exp_args);
    axi_read(12'h004, 0, rd); chk("gie_unmapped", rd, 32'h1);
    axi_read(12'h008, 0, rd); chk("ier_unmapped", rd, 32'h1);
    axi_read(12'h000, 0, rd); chk("ctrl_unmapped", rd, 32'h0C);

    // reset during a pending write response
    pulse_done;
    chk("irq_before_rst", interrupt, 1);
    axi_write(12'h000, 32'h81, 4'hF, 0);
    awaddr = 12'h020; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    tick;
    awvalid = 1'b0;
    tick;
    wvalid = 1'b0;
    chk("bvalid_pending", bvalid, 1);
    aresetn = 1'b0;
    tick;
    chk("bvalid_rst", bvalid, 0);
    chk("start_rst", ap_start, 0);
    chk("irq_rst", interrupt, 0);
    chk("args_rst", args, 0);
    aresetn = 1'b1;
    tick;
    chk("bvalid_after_rst", bvalid, 0);
    axi_read(12'h004, 0, rd); chk("gie_rst", rd, 32'h0);
    axi_read(12'h008, 0, rd); chk("ier_rst", rd, 32'h0);
    axi_read(12'h00C, 0, rd); chk("isr_rst", rd, 32'h0);
    axi_read(12'h000, 0, rd); chk("ctrl_rst", rd, 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
